// File: rtl/instruction_memory_loadable_if.sv
// rtl/instruction_memory_loadable_if.sv - load and fetch bus for the loadable instruction memory
interface instruction_memory_loadable_if #(
  parameter int SIZE_EXP2  = 10,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_done;
  logic [SIZE_EXP2:0]    load_count;
  logic                  load_full;
  logic                  ready;
  logic                  fetch_enable;
  logic                  stall;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  instruction_valid;
  logic                  fetch_fault;

  modport master (
    output load_valid, load_data, load_done, fetch_enable, stall, flush, pc,
    input  load_count, load_full, ready, instruction, instruction_valid, fetch_fault
  );

  modport slave (
    input  load_valid, load_data, load_done, fetch_enable, stall, flush, pc,
    output load_count, load_full, ready, instruction, instruction_valid, fetch_fault
  );
endinterface

// File: rtl/instruction_memory_loadable.sv
// rtl/instruction_memory_loadable.sv - instruction memory with sequential load phase and 1-cycle fetch
module instruction_memory_loadable #(
  parameter int                   SIZE_EXP2  = 10,
  parameter int                   DATA_WIDTH = 32,
  parameter int                   ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic                           system_clock,
  input  logic                           system_reset_n,
  instruction_memory_loadable_if.slave   bus
);
  localparam int DEPTH = 2 ** SIZE_EXP2;

  typedef enum logic {LOADING, RUNNING} state_t;

  state_t                state_q, state_d;
  logic [SIZE_EXP2:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  full;
  logic                  write_en;
  logic                  range_fault;
  logic                  fault;
  logic [SIZE_EXP2-1:0]  word_index;

  assign full       = (count_q == (SIZE_EXP2+1)'(DEPTH));
  assign write_en   = (state_q == LOADING) && bus.load_valid && !full;
  assign word_index = bus.pc[SIZE_EXP2+1:2];

  // Any set bit above the word index means pc >= DEPTH*4.
  generate
    if (ADDR_WIDTH > SIZE_EXP2 + 2) begin : g_range
      assign range_fault = |bus.pc[ADDR_WIDTH-1:SIZE_EXP2+2];
    end else begin : g_no_range
      assign range_fault = 1'b0;
    end
  endgenerate

  assign fault = (bus.pc[1:0] != 2'b00) || range_fault;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      LOADING: begin
        if (write_en) begin
          count_d = count_q + 1'b1;
        end
        if (bus.load_done) begin
          state_d = RUNNING;
        end
      end
      RUNNING: begin
        if (bus.flush) begin
          instr_d = NOP_VALUE;
          valid_d = 1'b0;
          fault_d = 1'b0;
        end else if (bus.stall) begin
          instr_d = instr_q;
        end else if (bus.fetch_enable) begin
          if (fault) begin
            instr_d = NOP_VALUE;
            valid_d = 1'b0;
            fault_d = 1'b1;
          end else begin
            instr_d = mem[word_index];
            valid_d = 1'b1;
            fault_d = 1'b0;
          end
        end else begin
          valid_d = 1'b0;
          fault_d = 1'b0;
        end
      end
      default: state_d = LOADING;
    endcase
  end

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q <= LOADING;
      count_q <= '0;
      instr_q <= NOP_VALUE;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // Storage is deliberately outside the reset so a program survives reset.
  always_ff @(posedge system_clock) begin
    if (write_en) begin
      mem[count_q[SIZE_EXP2-1:0]] <= bus.load_data;
    end
  end

  assign bus.load_count        = count_q;
  assign bus.load_full         = full;
  assign bus.ready             = (state_q == RUNNING);
  assign bus.instruction       = instr_q;
  assign bus.instruction_valid = valid_q;
  assign bus.fetch_fault       = fault_q;
endmodule
